// File: rtl/digital_mem_responder.sv
// Target-side model of the external digital memory: answers the read/write
// request/ready handshake from the RAM bridge with programmable wait states.
module digital_mem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            ramclk,
  input  logic            rst,
  input  logic [XLEN-1:0] digital_mem_addr,
  input  logic            digital_mem_read_en,
  input  logic            digital_mem_write_en,
  input  logic [3:0]      digital_mem_byte_size,
  input  logic [XLEN-1:0] digital_mem_wdata,
  output logic [XLEN-1:0] digital_mem_data,
  output logic            digital_mem_ready,
  output logic            digital_mem_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            wr_q;
  logic            ready_q;
  logic            err_q;
  logic [XLEN-1:0] data_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            en;
  logic [XLEN-1:0] off;
  logic [XLEN-1:0] word_off;
  logic [AW-1:0]   idx;
  logic            in_range;
  logic            access;
  logic            mem_we;
  logic [XLEN-1:0] data_d;

  // Range test is done on the captured address so mid-WAIT address changes
  // cannot affect which word is accessed.
  always_comb begin
    en       = digital_mem_read_en | digital_mem_write_en;
    off      = addr_q - BASE_ADDR;
    word_off = off >> 2;
    idx      = word_off[AW-1:0];
    in_range = (addr_q >= BASE_ADDR) && (word_off < XLEN'(DEPTH_WORDS));
    access   = (state_q == WAIT) && en && (cnt_q == '0);
    mem_we   = access && wr_q && in_range;
    data_d   = (!wr_q && in_range) ? mem[idx] : '0;
  end

  // Array has no reset; an async reset forces IDLE, which gates mem_we off.
  always_ff @(posedge ramclk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ramclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            addr_q  <= digital_mem_addr;
            wdata_q <= digital_mem_wdata;
            be_q    <= digital_mem_byte_size;
            wr_q    <= digital_mem_write_en;
            cnt_q   <= 4'(LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ready_q <= 1'b1;
            err_q   <= !in_range;
            data_q  <= data_d;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!en) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digital_mem_data  = data_q;
  assign digital_mem_ready = ready_q;
  assign digital_mem_err   = err_q;

endmodule

// File: doc/digital_mem_responder.md
Name: digital_mem_responder

Overview:
- Target-side model of the external digital memory interface: answers the `digital_mem_*` request/ready handshake that the RAM bridge drives.
- Backed by an internal word array with byte-lane writes and a programmable wait-state count.
- Sits outside the peripherals bus: in simulation top-levels it is the RAM device; on FPGA builds it wraps block RAM.
- Supports a four-phase handshake with abort, out-of-range detection and error flagging.

Parameters:
- XLEN, 32, data/address width; must be 32 (four byte lanes).
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- LATENCY, 2, wait-state cycles between request capture and access; 0..15.

Ports:
- ramclk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- digital_mem_addr  input  XLEN  byte address; bits [1:0] ignored (word aligned).
- digital_mem_read_en  input  1  read request, level, held until ready seen.
- digital_mem_write_en  input  1  write request, level, held until ready seen.
- digital_mem_byte_size  input  4  byte-lane enables; bit i selects bits [8i+7:8i].
- digital_mem_wdata  input  XLEN  write data.
- digital_mem_data  output  XLEN  read data, valid while ready=1 on a read.
- digital_mem_ready  output  1  access complete; held until both enables low.
- digital_mem_err  output  1  high with ready when the captured address was out of range.

Behaviour:
- Fixed interface: one clock; reset is asynchronous and active-high. Clock port is `ramclk`, reset port is `rst`.
- Reset values: digital_mem_ready=0, digital_mem_err=0, digital_mem_data=0, FSM=IDLE, wait counter=0.
- Reset does not clear array contents.
- Reset asserted mid-operation: any pending write is discarded and all outputs return to reset values immediately.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If read_en|write_en is sampled high at edge N: capture addr, wdata, byte_size and op, load cnt=LATENCY, go to WAIT.
  - If both enables are high, write wins and the op is recorded as a write.
- WAIT:
  - If both enables are sampled low: abort, go to IDLE. No access, no ready.
  - Else if cnt!=0: cnt decrements.
  - Else: perform the access, set ready=1 (and err if applicable), go to RESP.
  - Result: ready rises at edge N+1+LATENCY. LATENCY=0 gives ready at N+1.
  - Input changes during WAIT other than enables are ignored; captured values are used.
- Access:
  - Word index = (addr-BASE_ADDR)>>2.
  - In range when addr>=BASE_ADDR and index<DEPTH_WORDS; unsigned compare, no wrap-around of the subtraction.
  - Read: data<=array[index].
  - Write: lanes with byte_size bit set are updated in the same edge ready rises. byte_size=4'b0000 completes normally with no change.
  - Out of range: reads return 0, writes are dropped, ready=1 and err=1.
- RESP:
  - ready, err and data hold while read_en|write_en is high.
  - The edge sampling both enables low clears ready, err and data to 0 and returns to IDLE.
  - A new request needs at least one low-enable cycle, so an immediate back-to-back request is taken at the earliest on the next IDLE edge.
  - Enables switching read->write while in RESP are ignored; no second access occurs.
- Read-after-write to the same word returns the new data.
- Writes never take effect before ready.

Test Plan:
- LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, byte_size 4'hF, en high at edge 0 -> ready rises edge 3; drop en -> ready 0 at next edge. Read 0x10 -> data 0xDEADBEEF with ready at edge 3 of that request.
- Byte lanes: word 0x20=0x11223344, write 0xAABBCCDD with byte_size 4'b0101 -> readback 0x11BB33DD. Write with byte_size 0 -> unchanged, ready still asserted.
- Out of range, DEPTH_WORDS=1024, BASE 0: read 0x1000 -> ready=1, err=1, data=0. Write 0x1000 then read 0x0 -> word 0 unchanged.
- Abort: read_en high one cycle then low during WAIT -> ready never asserts and FSM is back in IDLE. A following read of 0x10 completes normally.
- Reset mid-operation: assert rst during WAIT of a write to 0x30 -> ready=0 immediately. After release, read 0x30 -> old value, write not applied.
- Simultaneous read_en and write_en with LATENCY=0, wdata 0x5 to 0x40 -> ready at edge 1, word 0x40=0x5. Latency sweep 0/1/7 -> ready at edges 1/2/8.
